add_seq_chunked: RTL and testbench

//   Parametrised multi-cycle adder/subtractor: adds CHUNK bits per clock and

---
 rtl/alu_pkg.sv | 28 ++
 rtl/add_chunk.sv | 23 ++
 rtl/add_seq_chunked.sv | 136 +++++++++++++
 tb/tb_add_seq_chunked.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, flag bit positions,
// sequencer state encoding and a small sizing helper.
package alu_pkg;

    // Operation select for the add/sub datapath
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    // Bit positions inside a packed {N,Z,V,C} flag vector
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
    localparam int NUM_FLAGS = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice. Besides sum and carry-out it
// reports the carry flowing into its MSB so the caller can derive
// signed overflow on the most significant slice.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign s        = w_full[CHUNK-1:0];
    assign co       = w_full[CHUNK];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of an XOR
    assign c_msb_in = w_full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/add_seq_chunked.sv
// Multi-cycle adder/subtractor. One CHUNK-bit slice is added per clock,
// with the inter-slice carry held in a register, so the critical path is
// a CHUNK-bit carry chain rather than a WIDTH-bit one.
module add_seq_chunked
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    // Reject slice sizes that do not tile the operand exactly
    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("add_seq_chunked: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t                 r_state;
    logic [IDXW-1:0]        r_idx;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_carry;
    logic [WIDTH-1:0]       r_sum;
    logic [NUM_FLAGS-1:0]   r_flags;
    logic                   r_out_valid;

    logic [CHUNK-1:0]       w_a_chunk;
    logic [CHUNK-1:0]       w_b_chunk;
    logic [CHUNK-1:0]       w_s_chunk;
    logic                   w_co;
    logic                   w_c_msb_in;
    logic [WIDTH-1:0]       w_sum_next;

    // Pick the slice addressed by the running index
    always_comb begin
        w_a_chunk = r_a[int'(r_idx) * CHUNK +: CHUNK];
        w_b_chunk = r_b[int'(r_idx) * CHUNK +: CHUNK];
    end

    add_chunk #(
        .CHUNK    (CHUNK)
    ) u_add_chunk (
        .a        (w_a_chunk),
        .b        (w_b_chunk),
        .ci       (r_carry),
        .s        (w_s_chunk),
        .co       (w_co),
        .c_msb_in (w_c_msb_in)
    );

    // Result with the current slice merged in; used for the zero flag too
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[int'(r_idx) * CHUNK +: CHUNK] = w_s_chunk;
    end

    // Sequencer: accept operands, add one slice per cycle, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert B once and seed the carry
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= (sub == ALU_OP_SUB) ? 1'b1 : c_in;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_co;
                    if (r_idx == LAST_IDX) begin
                        r_flags[FLAG_C] <= w_co;
                        r_flags[FLAG_V] <= w_c_msb_in ^ w_co;
                        r_flags[FLAG_Z] <= (w_sum_next == '0);
                        r_flags[FLAG_N] <= w_s_chunk[CHUNK-1];
                        r_out_valid     <= 1'b1;
                        r_state         <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_flags[FLAG_C];
    assign ovf       = r_flags[FLAG_V];
    assign zero      = r_flags[FLAG_Z];
    assign neg       = r_flags[FLAG_N];

endmodule

// File: tb/tb_add_seq_chunked.sv
// Bench for add_seq_chunked: a 16/4 instance driven from a vector table
// plus hand sequences (backpressure, reset abort), and a 32/8 instance
// driven randomly against a scoreboard of model results.
module tb_add_seq_chunked;

    localparam int N16 = 4;
    localparam int N32 = 4;
    localparam int NOPS32 = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv16, ir16, cin16, sub16, ov16, or16, co16, v16, z16, n16;
    logic [15:0] a16, b16, sum16;
    logic        iv32, ir32, cin32, sub32, ov32, or32, co32, v32, z32, n32;
    logic [31:0] a32, b32, sum32;

    add_seq_chunked #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .c_in(cin16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16), .sum(sum16),
        .c_out(co16), .ovf(v16), .zero(z16), .neg(n16)
    );

    add_seq_chunked #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .c_in(cin32), .sub(sub32),
        .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .c_out(co32), .ovf(v32), .zero(z32), .neg(n32)
    );

    typedef struct {
        logic [31:0] sum;
        logic        c, v, z, n;
    } res_t;

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] sum;
        logic        c, v, z, n;
    } vec_t;

    typedef struct {
        res_t r;
        int   acc;
    } sb_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    res_t q16[$];
    sb_t  q32[$];
    vec_t vt[9];

    always @(posedge clk) cyc <= cyc + 1;

    // Full-width reference: plain integer add, overflow from carries into/out of MSB
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [32:0] m, lm, full, low;
        logic [31:0] bb;
        logic        ci;
        m    = (33'd1 << w) - 33'd1;
        lm   = (33'd1 << (w - 1)) - 33'd1;
        bb   = sub ? ~b : b;
        ci   = sub ? 1'b1 : cin;
        full = ({1'b0, a} & m) + ({1'b0, bb} & m) + {32'd0, ci};
        low  = ({1'b0, a} & lm) + ({1'b0, bb} & lm) + {32'd0, ci};
        r.sum = full[31:0] & m[31:0];
        r.c   = full[w];
        r.v   = low[w-1] ^ full[w];
        r.z   = (r.sum == 32'd0);
        r.n   = r.sum[w-1];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [31:0] s, input logic c, input logic v,
                           input logic z, input logic n, input res_t e);
        chk({tag, "_sum"}, s, e.sum);
        chk({tag, "_c"}, 32'(c), 32'(e.c));
        chk({tag, "_v"}, 32'(v), 32'(e.v));
        chk({tag, "_z"}, 32'(z), 32'(e.z));
        chk({tag, "_n"}, 32'(n), 32'(e.n));
    endtask

    // One 16-bit operation: push expectation on accept, compare when result appears
    task automatic run16(input vec_t v, input bit hold, input string tag);
        int   n;
        res_t e;
        @(negedge clk);
        a16 = v.a; b16 = v.b; cin16 = v.cin; sub16 = v.sub; iv16 = 1'b1;
        n = 0;
        while (!ir16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ir16) begin
            chk({tag, "_accept_timeout"}, 32'(ir16), 32'd1);
            iv16 = 1'b0;
            return;
        end
        e.sum = {16'd0, v.sum}; e.c = v.c; e.v = v.v; e.z = v.z; e.n = v.n;
        q16.push_back(e);
        @(negedge clk);
        iv16 = 1'b0;
        n = 0;
        while (!ov16 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, N16);
        if (!ov16) return;
        e = q16.pop_front();
        chk_res(tag, {16'd0, sum16}, co16, v16, z16, n16, e);
        $display("T16 %s a=%h b=%h cin=%0d sub=%0d -> sum=%h c=%0d v=%0d z=%0d n=%0d lat=%0d",
                 tag, v.a, v.b, v.cin, v.sub, sum16, co16, v16, z16, n16, n);
        if (!hold) begin
            or16 = 1'b1;
            @(negedge clk);
            or16 = 1'b0;
        end
    endtask

    initial begin
        int   seen_ov;
        int   issued, done, guard;
        bit   seen;
        res_t e;
        sb_t  s;

        // a, b, cin, sub, sum, c, v, z, n
        vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[7] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8] = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 0;
        iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; or32 = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(ir16), 32'd0);
        chk("rst_out_valid", 32'(ov16), 32'd0);
        chk("rst_sum", {16'd0, sum16}, 32'd0);
        chk("rst_flags", {28'd0, co16, v16, z16, n16}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(ir16), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) run16(vt[i], 1'b0, $sformatf("vec%0d", i));

        // Backpressure: result held, new operands ignored
        run16(vt[8], 1'b1, "bp");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom_range(0, 1));
            chk("bp_out_valid", 32'(ov16), 32'd1);
            chk("bp_in_ready", 32'(ir16), 32'd0);
            chk("bp_sum", {16'd0, sum16}, 32'h3333);
            chk("bp_flags", {28'd0, co16, v16, z16, n16}, 32'd0);
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        chk("bp_release_out_valid", 32'(ov16), 32'd0);
        chk("bp_release_in_ready", 32'(ir16), 32'd1);
        seen_ov = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov16) seen_ov++;
        end
        chk("bp_ignored_inputs", seen_ov, 0);

        // Reset while RUN at idx 2 aborts the operation
        @(negedge clk);
        a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 0; sub16 = 0; iv16 = 1'b1;
        chk("abort_in_ready", 32'(ir16), 32'd1);
        @(negedge clk);
        iv16 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(ov16), 32'd0);
        chk("abort_sum", {16'd0, sum16}, 32'd0);
        chk("abort_flags", {28'd0, co16, v16, z16, n16}, 32'd0);
        chk("abort_in_ready", 32'(ir16), 32'd1);
        seen_ov = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov16) seen_ov++;
        end
        chk("abort_no_result", seen_ov, 0);
        run16('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0, "after_abort");

        // 32/8 instance: random traffic against the scoreboard
        issued = 0; done = 0; guard = 0; seen = 0;
        while (done < NOPS32 && guard < 60000) begin
            @(negedge clk);
            guard++;
            if (ov32) begin
                if (q32.size() == 0) begin
                    chk("r32_spurious_out_valid", 32'(ov32), 32'd0);
                    or32 = 1'b1;
                end else begin
                    if (!seen) begin
                        chk("r32_latency", cyc - q32[0].acc, N32);
                        seen = 1;
                    end
                    or32 = ($urandom_range(0, 3) != 0);
                    if (or32) begin
                        s = q32.pop_front();
                        chk_res("r32", sum32, co32, v32, z32, n32, s.r);
                        $display("T32 op %0d sum=%h c=%0d v=%0d z=%0d n=%0d", done, sum32, co32, v32, z32, n32);
                        seen = 0;
                        done++;
                    end
                end
            end else begin
                or32 = 1'($urandom_range(0, 1));
            end
            if (issued < NOPS32) begin
                iv32  = ($urandom_range(0, 2) != 0);
                a32   = $urandom;
                b32   = $urandom;
                cin32 = 1'($urandom_range(0, 1));
                sub32 = 1'($urandom_range(0, 1));
                if (iv32 && ir32) begin
                    s.r   = model(32, a32, b32, cin32, sub32);
                    s.acc = cyc + 1;
                    q32.push_back(s);
                    issued++;
                end
            end else begin
                iv32 = 1'b0;
            end
        end
        chk("r32_completed", done, NOPS32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
